md5_iter_core: RTL and testbench
================================

// Module: md5_iter_core
// PURPOSE
//  Iterative MD5 compression engine: next generation of md5core. Accepts one 512-bit padded block per transaction
//  over a valid/ready handshake; performs ROUNDS_PER_CYCLE MD5 steps per clock. Outputs the chained 128-bit digest.
//  Supports multi-block messages via chain input; a tag rides along per job. Sits between the block feeder and the
//  hash comparator; several instances run in parallel for brute-force search.
// PARAMETERS
//  ROUNDS_PER_CYCLE  1   MD5 steps per clock; legal 1,2,4,8,16; other values -> elaboration error
//  TAG_W             8   width of job tag passed from tag_in to tag_out
// PORTS
//  clk        in   1      system clock
//  reset_n    in   1      asynchronous, active-low reset
//  en         in   1      step enable; low freezes RUN progress (handshakes unaffected)
//  in_valid   in   1      block + chain + tag valid
//  in_ready   out  1      engine can accept a block
//  mesg       in   512    padded block; mesg[511:504] = first byte of stream
//  chain_en   in   1      1: start from chain_in; 0: start from MD5 IV
//  chain_in   in   128    {A,B,C,D} from previous block's digest
//  tag_in     in   TAG_W  job tag
//  out_valid  out  1      digest valid
//  out_ready  in   1      consumer accepts digest
//  digest     out  128    {A,B,C,D} after final add (raw word values, not byte-swapped)
//  tag_out    out  TAG_W  tag of the job in digest
//  busy       out  1      high in RUN
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, step counter=0, out_valid=0, digest=0, tag_out=0, busy=0; in_ready=1
//   after release. Assertion mid-job drops the job silently.
//  FSM: IDLE -> RUN on accept (in_valid&&in_ready). RUN -> DONE on last step edge. DONE -> IDLE on out_valid&&out_ready,
//   or DONE -> RUN if a new block is accepted in the same cycle.
//  in_ready = (state==IDLE) || (state==DONE && out_ready). Combinational in out_ready only; no in_valid->in_ready path.
//  Accept edge: latch M words, init value {A,B,C,D} = chain_en ? chain_in : IV, tag; step counter i=0.
//  IV: A=0x67452301 B=0xefcdab89 C=0x98badcfe D=0x10325476.
//  Word order: M[j] = byteswap32(mesg[511-32j -: 32]) (little-endian MD5 words).
//  Each RUN edge with en=1: apply steps i..i+R-1 (R = ROUNDS_PER_CYCLE) in a combinational chain; i += R, mod 64.
//   en=0 in RUN: all state holds, busy stays 1.
//  Step i: F/G/H/I by i/16; g index per RFC 1321; B' = B + rotl(A+f+K[i]+M[g], s[i]); (A,B,C,D) <= (D,B',B,C).
//  Last RUN edge (i+R==64): digest <= init + {A,B,C,D} (per-word mod 2^32); tag_out <= tag; out_valid <= 1.
//  Latency: out_valid rises 64/R enabled cycles after the accept edge (64 for R=1, 4 for R=16).
//  Back-pressure: digest, tag_out, out_valid hold stable until out_ready; no digest ever lost or overwritten.
//  Simultaneous drain + accept in DONE: out_valid falls and the new block enters RUN on the same edge.
//  in_valid ignored while in_ready=0; mesg/chain_in/tag_in sampled only on accept.
// STRUCTURE
//  md5_pkg: K[0:63] table, shift table s[0:63], IV constants, function msg_index(i), function byteswap32.
//  Sub-module md5_step: one combinational step (inputs A,B,C,D,M word, step index; outputs next A,B,C,D);
//   generate-instantiated R times in series. Top holds FSM, step counter, message regs, init regs, output regs.
// TESTING (run for R=1, 4 and 16)
//  1 "The quick brown fox jumps over the lazy dog" padded block (len 0x158 bits), chain_en=0 -> digest
//    {9d7d109e,82b62b37,351dd86b,d619a442} (= 9e107d9d372bb6826bd81d3542a419d6), latency exactly 64/R.
//  2 Empty message, mesg=512'h80000000_00..00, chain_en=0 -> digest {d98c1dd4,04b2008f,980980e9,7e42f8ec}.
//  3 Two-block message "a"x64: block 1 chain_en=0, block 2 (pad) chain_en=1 chain_in=digest1 -> final digest matches
//    reference model MD5; tag_out tracks tag 0x11 then 0x22.
//  4 out_ready held low 10 cycles after out_valid -> digest/tag stable, in_ready=0; then out_ready=1 with in_valid=1
//    -> drain and accept on same edge, second digest after 64/R cycles.
//  5 en toggled 50% random during RUN -> correct digest (test 1 value), latency = 64/R enabled cycles.
//  6 reset_n pulsed low mid-RUN -> out_valid=0, busy=0 immediately; next job after release gives correct digest.

Source files
------------

// File: rtl/md5_pkg.sv
// rtl/md5_pkg.sv - MD5 constants, FSM state type and index/byte-order helpers
package md5_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  localparam logic [31:0] K_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Rotate amounts repeat every four steps within a round: index {round, step%4}
  localparam logic [4:0] S_TAB [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21
  };

  function automatic logic [4:0] shift_amt(input logic [5:0] i);
    return S_TAB[{i[5:4], i[1:0]}];
  endfunction

  // Message word used by step i; 4-bit arithmetic gives the mod-16 wrap for free
  function automatic logic [3:0] msg_index(input logic [5:0] i);
    case (i[5:4])
      2'd0:    return i[3:0];
      2'd1:    return i[3:0] * 4'd5 + 4'd1;
      2'd2:    return i[3:0] * 4'd3 + 4'd5;
      default: return i[3:0] * 4'd7;
    endcase
  endfunction

  function automatic logic [31:0] byteswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/md5_step.sv
// rtl/md5_step.sv - one combinational MD5 step
module md5_step
  import md5_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  input  logic [31:0] m_i,
  input  logic [5:0]  idx_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o
);

  logic [31:0] f;
  logic [31:0] sum;
  logic [31:0] rot;
  logic [4:0]  sh;
  logic [5:0]  sh_inv;

  // Round function selected by the step's quarter, then add, rotate and shuffle
  always_comb begin
    f = 32'd0;
    case (idx_i[5:4])
      2'd0:    f = (b_i & c_i) | (~b_i & d_i);
      2'd1:    f = (d_i & b_i) | (~d_i & c_i);
      2'd2:    f = b_i ^ c_i ^ d_i;
      default: f = c_i ^ (b_i | ~d_i);
    endcase
    sum    = a_i + f + K_TAB[idx_i] + m_i;
    sh     = shift_amt(idx_i);
    sh_inv = 6'd32 - {1'b0, sh};
    rot    = (sum << sh) | (sum >> sh_inv);
    a_o    = d_i;
    b_o    = b_i + rot;
    c_o    = b_i;
    d_o    = c_i;
  end

endmodule

// File: rtl/md5_iter_core.sv
// rtl/md5_iter_core.sv - iterative MD5 compression engine with valid/ready job interface
module md5_iter_core
  import md5_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int TAG_W            = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [511:0]       mesg,
  input  logic               chain_en,
  input  logic [127:0]       chain_in,
  input  logic [TAG_W-1:0]   tag_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       digest,
  output logic [TAG_W-1:0]   tag_out,
  output logic               busy
);

  localparam int R = ROUNDS_PER_CYCLE;

  if (!(R == 1 || R == 2 || R == 4 || R == 8 || R == 16)) begin : g_bad_rounds
    $error("md5_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  state_e           state_q;
  logic [5:0]       i_q;
  logic [31:0]      m_q [16];
  logic [127:0]     init_q;
  logic [127:0]     abcd_q;
  logic [TAG_W-1:0] tag_q;
  logic [127:0]     digest_q;
  logic [TAG_W-1:0] tag_out_q;
  logic             out_valid_q;
  logic             busy_q;

  logic             accept;
  logic             last_step;
  logic [127:0]     init_d;
  logic [127:0]     abcd_d;
  logic [127:0]     sum_d;

  // A finished digest may leave on the same edge a new block arrives
  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign init_d    = chain_en ? chain_in : {IV_A, IV_B, IV_C, IV_D};
  assign last_step = (i_q == 6'(64 - R));

  // R steps chained combinationally; stage k works on step i_q+k
  for (genvar k = 0; k < R; k++) begin : g_step
    logic [31:0] a_p, b_p, c_p, d_p;
    logic [31:0] a_n, b_n, c_n, d_n;
    logic [5:0]  idx;
    logic [31:0] mw;

    if (k == 0) begin : g_first
      assign {a_p, b_p, c_p, d_p} = abcd_q;
    end else begin : g_next
      assign {a_p, b_p, c_p, d_p} = {g_step[k-1].a_n, g_step[k-1].b_n,
                                     g_step[k-1].c_n, g_step[k-1].d_n};
    end

    assign idx = i_q + 6'(k);
    assign mw  = m_q[msg_index(idx)];

    md5_step u_step (
      .a_i  (a_p),
      .b_i  (b_p),
      .c_i  (c_p),
      .d_i  (d_p),
      .m_i  (mw),
      .idx_i(idx),
      .a_o  (a_n),
      .b_o  (b_n),
      .c_o  (c_n),
      .d_o  (d_n)
    );
  end

  assign abcd_d = {g_step[R-1].a_n, g_step[R-1].b_n, g_step[R-1].c_n, g_step[R-1].d_n};
  assign sum_d  = {init_q[127:96] + abcd_d[127:96], init_q[95:64] + abcd_d[95:64],
                   init_q[63:32]  + abcd_d[63:32],  init_q[31:0]  + abcd_d[31:0]};

  assign out_valid = out_valid_q;
  assign digest    = digest_q;
  assign tag_out   = tag_out_q;
  assign busy      = busy_q;

  // Job FSM: load on accept, iterate while enabled, hold result until drained
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      i_q         <= 6'd0;
      for (int j = 0; j < 16; j++) m_q[j] <= 32'd0;
      init_q      <= 128'd0;
      abcd_q      <= 128'd0;
      tag_q       <= '0;
      digest_q    <= 128'd0;
      tag_out_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (accept) begin
        for (int j = 0; j < 16; j++) m_q[j] <= byteswap32(mesg[511-32*j -: 32]);
        init_q  <= init_d;
        abcd_q  <= init_d;
        tag_q   <= tag_in;
        i_q     <= 6'd0;
        busy_q  <= 1'b1;
        state_q <= ST_RUN;
      end
      case (state_q)
        ST_IDLE: ;
        ST_RUN: begin
          if (en) begin
            abcd_q <= abcd_d;
            i_q    <= i_q + 6'(R);
            if (last_step) begin
              digest_q    <= sum_d;
              tag_out_q   <= tag_q;
              out_valid_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (!accept) state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_iter_core.sv
// tb/tb_md5_iter_core.sv - scoreboard bench running R=1, 4 and 16 engines in lockstep
module tb_md5_iter_core;

  localparam int ND = 3;
  localparam logic [127:0] FOX_DG   = 128'h9d7d109e_82b62b37_351dd86b_d619a442;
  localparam logic [127:0] EMPTY_DG = 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec;
  localparam logic [127:0] IV       = 128'h67452301_efcdab89_98badcfe_10325476;

  typedef struct packed {
    logic [127:0] dg;
    logic [7:0]   tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic          in_valid = 1'b0;
  logic [511:0]  mesg = '0;
  logic          chain_en = 1'b0;
  logic [127:0]  chain_in = '0;
  logic [7:0]    tag_in = '0;
  logic          out_ready = 1'b0;

  logic [ND-1:0] in_ready_w;
  logic [ND-1:0] out_valid_w;
  logic [ND-1:0] busy_w;
  logic [127:0]  digest_w [ND];
  logic [7:0]    tag_w [ND];

  int            n_cmp = 0;
  int            n_bad = 0;
  exp_t          exp_q[$];
  int            rd_ptr [ND];
  int            lat_cnt [ND];
  bit            counting [ND];
  bit            rand_en = 0;
  bit            rand_or = 0;
  logic [31:0]   ktab [64];
  int            sh_t [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
  real           kv;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    md5_iter_core #(
      .ROUNDS_PER_CYCLE((g == 0) ? 1 : ((g == 1) ? 4 : 16)),
      .TAG_W(8)
    ) u_dut (
      .clk      (clk),
      .reset_n  (rst_n),
      .en       (en),
      .in_valid (in_valid),
      .in_ready (in_ready_w[g]),
      .mesg     (mesg),
      .chain_en (chain_en),
      .chain_in (chain_in),
      .tag_in   (tag_in),
      .out_valid(out_valid_w[g]),
      .out_ready(out_ready),
      .digest   (digest_w[g]),
      .tag_out  (tag_w[g]),
      .busy     (busy_w[g])
    );
  end

  function automatic int rof(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 4 : 16);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", nm, act, req);
    end
  endtask

  // RFC 1321 compression of one block, written straight from the algorithm text
  function automatic logic [127:0] md5_ref(input logic [127:0] chain, input logic [511:0] blk);
    logic [31:0] w [16];
    logic [31:0] a, b, c, d, f, t, nb;
    int gi, sh;
    for (int j = 0; j < 16; j++)
      w[j] = {blk[487-32*j -: 8], blk[495-32*j -: 8], blk[503-32*j -: 8], blk[511-32*j -: 8]};
    {a, b, c, d} = chain;
    for (int i = 0; i < 64; i++) begin
      case (i / 16)
        0: begin f = (b & c) | (~b & d); gi = i; end
        1: begin f = (d & b) | (~d & c); gi = (5 * i + 1) % 16; end
        2: begin f = b ^ c ^ d;          gi = (3 * i + 5) % 16; end
        default: begin f = c ^ (b | ~d); gi = (7 * i) % 16; end
      endcase
      sh = sh_t[(i / 16) * 4 + (i % 4)];
      t  = a + f + ktab[i] + w[gi];
      t  = (t << sh) | (t >> (32 - sh));
      nb = b + t;
      a = d; d = c; c = b; b = nb;
    end
    return {chain[127:96] + a, chain[95:64] + b, chain[63:32] + c, chain[31:0] + d};
  endfunction

  function automatic logic [511:0] pad_msg(input string s);
    logic [511:0] blk;
    logic [63:0]  bits;
    int n;
    blk  = '0;
    n    = s.len();
    bits = 64'(n * 8);
    for (int k = 0; k < n; k++) blk[511-8*k -: 8] = s[k];
    blk[511-8*n -: 8] = 8'h80;
    for (int k = 0; k < 8; k++) blk[511-8*(56+k) -: 8] = bits[8*k +: 8];
    return blk;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [511:0] m, input bit ce, input logic [127:0] ci,
                       input logic [7:0] tg, input logic [127:0] expd, input bit push);
    int b;
    b = 0;
    while (in_ready_w != '1 && b < 600) begin
      tick();
      b++;
    end
    if (in_ready_w != '1) chk("in_ready before issue", 128'(in_ready_w), 128'(3'b111));
    mesg     = m;
    chain_en = ce;
    chain_in = ci;
    tag_in   = tg;
    in_valid = 1'b1;
    if (push) exp_q.push_back('{dg: expd, tag: tg});
    tick();
    in_valid = 1'b0;
    mesg     = {16{$urandom()}};
    chain_in = {4{$urandom()}};
    tag_in   = 8'($urandom());
    chain_en = 1'($urandom());
  endtask

  task automatic wait_drained();
    int b;
    int n_ok;
    b = 0;
    n_ok = 0;
    while (b < 800) begin
      n_ok = 0;
      for (int g = 0; g < ND; g++) if (rd_ptr[g] == exp_q.size()) n_ok++;
      if (n_ok == ND) break;
      tick();
      b++;
    end
    if (n_ok != ND) chk("drain timeout engines done", 128'(n_ok), 128'(ND));
  endtask

  task automatic wait_all_valid();
    int b;
    b = 0;
    while (out_valid_w != '1 && b < 400) begin
      tick();
      b++;
    end
    if (out_valid_w != '1) chk("out_valid wait", 128'(out_valid_w), 128'(3'b111));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_en) en = 1'($urandom());
      if (rand_or) out_ready = ($urandom() % 4) != 0;
    end
  end

  // Monitor: latency in enabled cycles and in-order digest/tag scoreboard per engine
  initial begin
    exp_t e;
    for (int g = 0; g < ND; g++) begin
      rd_ptr[g] = 0; lat_cnt[g] = 0; counting[g] = 0;
    end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int g = 0; g < ND; g++) counting[g] = 0;
      end else begin
        for (int g = 0; g < ND; g++) begin
          if (counting[g] && out_valid_w[g]) begin
            chk($sformatf("r%0d latency", rof(g)), 128'(lat_cnt[g]), 128'(64 / rof(g)));
            counting[g] = 0;
          end
          if (in_valid && in_ready_w[g]) begin
            counting[g] = 1;
            lat_cnt[g]  = 0;
          end else if (counting[g]) begin
            lat_cnt[g] += int'(en);
          end
          if (out_valid_w[g] && out_ready) begin
            if (rd_ptr[g] >= exp_q.size()) begin
              chk($sformatf("r%0d unexpected digest count", rof(g)),
                  128'(rd_ptr[g] + 1), 128'(exp_q.size()));
            end else begin
              e = exp_q[rd_ptr[g]];
              chk($sformatf("r%0d digest job %0d", rof(g), rd_ptr[g]), digest_w[g], e.dg);
              chk($sformatf("r%0d tag job %0d", rof(g), rd_ptr[g]), 128'(tag_w[g]), 128'(e.tag));
              rd_ptr[g]++;
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] blk_a, blk_pad, m;
    logic [127:0] d1, d2, ci;
    bit ce;

    for (int i = 0; i < 64; i++) begin
      kv = $sin(real'(i + 1));
      if (kv < 0.0) kv = -kv;
      ktab[i] = 32'(longint'($floor(kv * 4294967296.0)));
    end

    // Reset values
    tick(); tick();
    for (int g = 0; g < ND; g++) begin
      chk($sformatf("r%0d reset out_valid", rof(g)), 128'(out_valid_w[g]), 128'(0));
      chk($sformatf("r%0d reset digest", rof(g)), digest_w[g], 128'(0));
      chk($sformatf("r%0d reset tag_out", rof(g)), 128'(tag_w[g]), 128'(0));
      chk($sformatf("r%0d reset busy", rof(g)), 128'(busy_w[g]), 128'(0));
    end
    rst_n = 1'b1;
    tick();
    chk("in_ready after reset", 128'(in_ready_w), 128'(3'b111));
    out_ready = 1'b1;

    // Known vectors
    issue(pad_msg("The quick brown fox jumps over the lazy dog"), 1'b0, {4{$urandom()}},
          8'h01, FOX_DG, 1'b1);
    wait_drained();
    issue(pad_msg(""), 1'b0, '0, 8'h02, EMPTY_DG, 1'b1);
    wait_drained();

    // Two-block message chained through chain_in
    blk_a   = {64{8'h61}};
    blk_pad = {8'h80, 440'd0, 8'h00, 8'h02, 48'd0};
    d1 = md5_ref(IV, blk_a);
    d2 = md5_ref(d1, blk_pad);
    issue(blk_a, 1'b0, {4{$urandom()}}, 8'h11, d1, 1'b1);
    issue(blk_pad, 1'b1, d1, 8'h22, d2, 1'b1);
    wait_drained();

    // Back-pressure hold, then drain and accept on one edge
    out_ready = 1'b0;
    issue(pad_msg(""), 1'b0, '0, 8'h33, EMPTY_DG, 1'b1);
    wait_all_valid();
    for (int c = 0; c < 10; c++) begin
      for (int g = 0; g < ND; g++) begin
        chk($sformatf("r%0d held digest", rof(g)), digest_w[g], EMPTY_DG);
        chk($sformatf("r%0d held tag", rof(g)), 128'(tag_w[g]), 128'(8'h33));
        chk($sformatf("r%0d held out_valid", rof(g)), 128'(out_valid_w[g]), 128'(1));
        chk($sformatf("r%0d held in_ready", rof(g)), 128'(in_ready_w[g]), 128'(0));
      end
      tick();
    end
    out_ready = 1'b1;
    issue(pad_msg("The quick brown fox jumps over the lazy dog"), 1'b0, '0, 8'h44, FOX_DG, 1'b1);
    for (int g = 0; g < ND; g++) begin
      chk($sformatf("r%0d out_valid after drain", rof(g)), 128'(out_valid_w[g]), 128'(0));
      chk($sformatf("r%0d busy after drain+accept", rof(g)), 128'(busy_w[g]), 128'(1));
    end
    wait_drained();

    // Random step enable
    rand_en = 1;
    issue(pad_msg("The quick brown fox jumps over the lazy dog"), 1'b0, '0, 8'h55, FOX_DG, 1'b1);
    wait_drained();
    rand_en = 0;
    en = 1'b1;

    // Reset mid-job drops it
    issue(pad_msg("abc"), 1'b0, '0, 8'h5a, '0, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < ND; g++) begin
      chk($sformatf("r%0d out_valid in reset", rof(g)), 128'(out_valid_w[g]), 128'(0));
      chk($sformatf("r%0d busy in reset", rof(g)), 128'(busy_w[g]), 128'(0));
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    issue(pad_msg(""), 1'b0, '0, 8'h66, EMPTY_DG, 1'b1);
    wait_drained();

    // Random blocks, chains, enable and back-pressure
    rand_en = 1;
    rand_or = 1;
    for (int n = 0; n < 8; n++) begin
      for (int w = 0; w < 16; w++) m[511-32*w -: 32] = $urandom();
      ce = 1'($urandom());
      ci = {$urandom(), $urandom(), $urandom(), $urandom()};
      issue(m, ce, ci, 8'($urandom()), md5_ref(ce ? ci : IV, m), 1'b1);
    end
    wait_drained();
    rand_en = 0;
    rand_or = 0;
    en = 1'b1;
    out_ready = 1'b1;
    tick();

    for (int g = 0; g < ND; g++)
      chk($sformatf("r%0d digests delivered", rof(g)), 128'(rd_ptr[g]), 128'(exp_q.size()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
